// File: rtl/snf_flit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : snf_flit_tx
//  Brief    : Credit-based flit transmitter draining a local flit FIFO onto a
//             link channel. A STOP/ACT/RUN/DEACT link FSM gates data sends;
//             during deactivation every held L-credit is handed back as a
//             zero-payload credit-return flit.
//  Options  : SNF_FLIT_TX_PEND_EN - when defined, txflitpend is a precise
//             one-cycle early warning of txflitv; otherwise it is tied high.
//  Revision : 1.0 - initial release
// ============================================================================
module snf_flit_tx #(
  parameter int FLIT_WIDTH = 64,
  parameter int MAX_CRD    = 4,
  localparam int CRD_W     = $clog2(MAX_CRD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_en,
  input  logic                  fifo_empty,
  input  logic [FLIT_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  txflitpend,
  output logic                  txflitv,
  output logic [FLIT_WIDTH-1:0] txflit,
  output logic                  txlcrdrtn,
  input  logic                  txlcrdv,
  output logic                  link_active,
  output logic [CRD_W-1:0]      crd_cnt,
  output logic                  crd_err
);

  // Saturation limit in counter width and in the one-bit-wider sum width.
  localparam logic [CRD_W-1:0] MAX_CRD_C   = CRD_W'(MAX_CRD);
  localparam logic [CRD_W:0]   MAX_CRD_EXT = (CRD_W + 1)'(MAX_CRD);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_ACT   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DEACT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            have_crd;   // registered count is non-zero
  logic            send;       // pop a data flit and present it next cycle
  logic            rtn;        // present a credit-return flit next cycle
  logic            spend;      // one credit consumed this cycle
  logic            crd_in;     // one credit accepted this cycle
  logic [CRD_W:0]  crd_sum;    // next count before saturation
  logic            crd_ovf;    // next count would exceed MAX_CRD

  // Only the registered count may be spent: a credit arriving this cycle is
  // not usable until the next one, which keeps the pop path free of txlcrdv.
  assign have_crd    = (crd_cnt != '0);
  assign send        = (state == ST_RUN) && !fifo_empty && have_crd;
  assign rtn         = (state == ST_DEACT) && have_crd;
  assign spend       = send || rtn;
  assign crd_in      = txlcrdv && (state != ST_STOP);
  assign fifo_rd_en  = send;
  assign link_active = (state == ST_RUN);

`ifdef SNF_FLIT_TX_PEND_EN
  // Exactly the condition that will load txflitv on the next edge.
  assign txflitpend = spend;
`else
  // Always-pending is protocol-legal; the receiver simply keeps listening.
  assign txflitpend = 1'b1;
`endif

  // Link FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Link FSM next-state; DEACT only exits once every credit has been handed
  // back and no new credit is arriving, so no credit is ever stranded.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  if (link_en) state_nxt = ST_ACT;
      ST_ACT:   state_nxt = link_en ? ST_RUN : ST_DEACT;
      ST_RUN:   if (!link_en) state_nxt = ST_DEACT;
      ST_DEACT: if (!have_crd && !txlcrdv) state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  // Credit arithmetic in one extra bit so overflow is visible, not wrapped.
  // Spending never underflows because both send and rtn require a credit.
  always_comb begin
    crd_sum = {1'b0, crd_cnt}
            + {{CRD_W{1'b0}}, crd_in}
            - {{CRD_W{1'b0}}, spend};
    crd_ovf = (crd_sum > MAX_CRD_EXT);
  end

  // Credit counter with saturation and a sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crd_cnt <= '0;
      crd_err <= 1'b0;
    end else if (crd_ovf) begin
      crd_cnt <= MAX_CRD_C;
      crd_err <= 1'b1;
    end else begin
      crd_cnt <= crd_sum[CRD_W-1:0];
    end
  end

  // Registered flit channel; payload holds its last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txflitv   <= 1'b0;
      txflit    <= '0;
      txlcrdrtn <= 1'b0;
    end else if (send) begin
      txflitv   <= 1'b1;
      txflit    <= fifo_rd_data;
      txlcrdrtn <= 1'b0;
    end else if (rtn) begin
      txflitv   <= 1'b1;
      txflit    <= '0;
      txlcrdrtn <= 1'b1;
    end else begin
      txflitv   <= 1'b0;
      txlcrdrtn <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snf_flit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snf_flit_tx
//  Brief    : Self-checking bench for snf_flit_tx. A small array FIFO feeds
//             the DUT; expected flits are queued as stimulus is applied and
//             compared as txflitv presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snf_flit_tx;

  localparam int FLIT_WIDTH = 64;
  localparam int MAX_CRD    = 4;
  localparam int CRD_W      = $clog2(MAX_CRD + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  link_en = 1'b0;
  logic                  txlcrdv = 1'b0;
  logic                  fifo_empty;
  logic [FLIT_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  txflitpend;
  logic                  txflitv;
  logic [FLIT_WIDTH-1:0] txflit;
  logic                  txlcrdrtn;
  logic                  link_active;
  logic [CRD_W-1:0]      crd_cnt;
  logic                  crd_err;

  // Source FIFO model: bench writes mem/wr_ptr, the pop process owns rd_ptr.
  logic [FLIT_WIDTH-1:0] mem [0:255];
  logic [7:0]            wr_ptr = 8'd0;
  logic [7:0]            rd_ptr = 8'd0;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  // Expected flits as {txlcrdrtn, txflit}.
  logic [FLIT_WIDTH:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  snf_flit_tx #(.FLIT_WIDTH(FLIT_WIDTH), .MAX_CRD(MAX_CRD)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_en      (link_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txflitpend   (txflitpend),
    .txflitv      (txflitv),
    .txflit       (txflit),
    .txlcrdrtn    (txlcrdrtn),
    .txlcrdv      (txlcrdv),
    .link_active  (link_active),
    .crd_cnt      (crd_cnt),
    .crd_err      (crd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLIT_WIDTH-1:0] flit_val(input int i);
    flit_val = {32'hF1170000 + 32'(i), 32'hCAFE0000 ^ 32'(i * 7 + 1)};
  endfunction

  // Load a flit into the source FIFO; optionally expect it on the link.
  task automatic load(input int i, input bit expect_it);
    mem[wr_ptr] = flit_val(i);
    wr_ptr      = wr_ptr + 8'd1;
    if (expect_it) exp_q.push_back({1'b0, flit_val(i)});
  endtask

  // Advance one clock; inputs change and checks happen 2 time units later.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // FIFO pop follows the DUT's strobe as seen at the clock edge.
  always @(posedge clk) begin
    if (!rst && fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  // Output monitor: scoreboard compare, pop-to-valid latency, pend warning.
  logic pop_d  = 1'b0;
  logic pend_d = 1'b0;
  logic prev_ok = 1'b0;
  always @(negedge clk) begin
    logic [FLIT_WIDTH:0] e;
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (txflitv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", {15'd0, txlcrdrtn, txflit}, 80'd0);
        end else begin
          e = exp_q.pop_front();
          check("flit", {15'd0, txlcrdrtn, txflit}, {15'd0, e});
        end
        if (!txlcrdrtn && prev_ok) check("pop_latency", 80'(pop_d), 80'd1);
      end
`ifdef SNF_FLIT_TX_PEND_EN
      if (prev_ok) check("pend_early", 80'(txflitv), 80'(pend_d));
`else
      check("pend_tied", 80'(txflitpend), 80'd1);
`endif
      prev_ok = 1'b1;
    end
    pop_d  = fifo_rd_en;
    pend_d = txflitpend;
  end

  initial begin
    // ---- Reset and bring-up with no credits ----
    load(0, 1'b1);            // A
    load(1, 1'b1);            // B
    load(2, 1'b1);            // C
    tick(2);
    check("rst_crd",    80'(crd_cnt),     80'd0);
    check("rst_flitv",  80'(txflitv),     80'd0);
    check("rst_flit",   80'(txflit),      80'd0);
    check("rst_rtn",    80'(txlcrdrtn),   80'd0);
    check("rst_active", 80'(link_active), 80'd0);
    check("rst_err",    80'(crd_err),     80'd0);
    check("rst_rd_en",  80'(fifo_rd_en),  80'd0);
    rst     = 1'b0;
    link_en = 1'b1;
    tick(1);                  // STOP -> ACT
    check("act_active", 80'(link_active), 80'd0);
    tick(1);                  // ACT -> RUN
    check("run_active", 80'(link_active), 80'd1);
    check("run_rd_en0", 80'(fifo_rd_en),  80'd0);
    check("run_crd0",   80'(crd_cnt),     80'd0);
    tick(1);
    check("run_flitv0", 80'(txflitv),     80'd0);

    // ---- Two credit pulses: A and B sent, C held ----
    // The first two expected entries (A, B) are already queued; C is
    // reclassified below since it stays in the FIFO until later.
    txlcrdv = 1'b1;
    exp_q.delete(2);
    tick(2);
    txlcrdv = 1'b0;
    tick(3);
    check("two_crd_cnt", 80'(crd_cnt),         80'd0);
    check("two_fifo_lv", 80'(wr_ptr - rd_ptr), 80'd1);
    check("two_exp_emp", 80'(exp_q.size()),    80'd0);

    // ---- Steady credits: C plus 8 flits back-to-back, count pinned at 1 ----
    exp_q.push_back({1'b0, flit_val(2)});
    for (int i = 0; i < 8; i++) load(10 + i, 1'b1);
    txlcrdv = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      check("b2b_crd",   80'(crd_cnt),    80'd1);
      check("b2b_rd_en", 80'(fifo_rd_en), 80'd1);
      tick(1);
    end
    check("b2b_done_crd", 80'(crd_cnt),    80'd1);
    check("b2b_done_rd",  80'(fifo_rd_en), 80'd0);

    // ---- Credits accumulate with empty FIFO, then overflow ----
    tick(3);
    check("max_crd",      80'(crd_cnt), 80'(MAX_CRD));
    check("max_err0",     80'(crd_err), 80'd0);
    tick(1);
    check("ovf_crd",      80'(crd_cnt), 80'(MAX_CRD));
    check("ovf_err",      80'(crd_err), 80'd1);
    tick(2);
    txlcrdv = 1'b0;
    check("ovf_crd_hold", 80'(crd_cnt), 80'(MAX_CRD));
    check("ovf_err_hold", 80'(crd_err), 80'd1);

    // ---- Spend one, then deactivate with 3 credits held ----
    load(20, 1'b1);
    tick(1);
    check("deact_pre_crd", 80'(crd_cnt), 80'd3);
    link_en = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, {FLIT_WIDTH{1'b0}}});
    tick(1);                  // RUN -> DEACT
    check("deact_active", 80'(link_active), 80'd0);
    load(21, 1'b0);           // must not be popped while deactivating
    tick(3);
    check("deact_crd0",   80'(crd_cnt), 80'd0);
    tick(2);
    check("stop_fifo_lv", 80'(wr_ptr - rd_ptr), 80'd1);
    check("stop_rd_en",   80'(fifo_rd_en),      80'd0);
    check("stop_exp_emp", 80'(exp_q.size()),    80'd0);
    check("stop_err",     80'(crd_err),         80'd1);
    txlcrdv = 1'b1;           // ignored in STOP
    tick(1);
    txlcrdv = 1'b0;
    tick(1);
    check("stop_ignore_crd", 80'(crd_cnt), 80'd0);

    // ---- Relink, send the held flit, then reset mid-operation ----
    link_en = 1'b1;
    exp_q.push_back({1'b0, flit_val(21)});
    tick(2);                  // STOP -> ACT -> RUN
    txlcrdv = 1'b1;
    tick(1);
    txlcrdv = 1'b0;
    tick(2);
    check("relink_exp_emp", 80'(exp_q.size()), 80'd0);
    txlcrdv = 1'b1;
    tick(1);
    txlcrdv = 1'b0;
    check("pre_rst_crd", 80'(crd_cnt), 80'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_crd",    80'(crd_cnt),     80'd0);
    check("mid_rst_err",    80'(crd_err),     80'd0);
    check("mid_rst_flit",   80'(txflit),      80'd0);
    check("mid_rst_active", 80'(link_active), 80'd0);
    tick(2);
    check("final_exp_emp",  80'(exp_q.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/snf_flit_tx.md
Name: snf_flit_tx

Overview:
Credit-based flit transmitter for the drain side of a flit buffer. It pops flits from a local FIFO using an empty / rd_en / rd_data interface, where rd_data is valid combinationally at the read pointer. It drives them onto a link channel whose receiver returns L-credits one at a time. A link FSM (STOP/ACT/RUN/DEACT) gates sending. During deactivation, every held credit is handed back as a credit-return flit.

Parameters:
FLIT_WIDTH, 64, flit payload width in bits
MAX_CRD, 4, maximum L-credits the receiver may grant (1..15); counter width CRD_W = $clog2(MAX_CRD+1)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
link_en  input  1  request link up (1) or down (0)
fifo_empty  input  1  source FIFO empty
fifo_rd_data  input  FLIT_WIDTH  head flit of source FIFO, combinational
fifo_rd_en  output  1  pop strobe to source FIFO (combinational)
txflitpend  output  1  early-warning that txflitv may assert next cycle
txflitv  output  1  flit valid, registered
txflit  output  FLIT_WIDTH  flit payload, registered
txlcrdrtn  output  1  qualifies txflitv as a credit-return flit (payload zero)
txlcrdv  input  1  one L-credit returned by receiver this cycle
link_active  output  1  high in state RUN
crd_cnt  output  CRD_W  current credit count (debug)
crd_err  output  1  sticky credit-overflow error

Behaviour:
- Reset: state=STOP, crd_cnt=0, txflitv=0, txflit=0, txlcrdrtn=0, link_active=0, crd_err=0, fifo_rd_en=0.
- FSM, 2-bit, registered:
  - STOP: txlcrdv is ignored (not counted). Go to ACT when link_en=1.
  - ACT: credits are counted; no sends. Go to RUN next cycle if link_en=1; otherwise go to DEACT.
  - RUN: normal send. Go to DEACT when link_en=0.
  - DEACT: no data sends; return credits. Go to STOP when crd_cnt==0 and txlcrdv==0.
- send = (state==RUN) & ~fifo_empty & (crd_cnt!=0). Only the registered count is used; a credit arriving this cycle is not spendable until the next cycle.
- fifo_rd_en = send.
- On send: txflitv<=1, txflit<=fifo_rd_data, txlcrdrtn<=0. Latency is 1 cycle from pop to txflitv.
- rtn = (state==DEACT) & (crd_cnt!=0). On rtn: txflitv<=1, txflit<=0, txlcrdrtn<=1.
- Otherwise txflitv<=0 and txlcrdrtn<=0. txflit holds its last value.
- Credit counter: crd_ns = crd_cnt + (txlcrdv & state!=STOP) - (send|rtn), evaluated in CRD_W+1 bits.
  - Simultaneous credit-in and spend: count is unchanged.
  - Overflow (crd_cnt==MAX_CRD, credit in, no spend): count saturates at MAX_CRD and crd_err<=1. crd_err clears only on reset.
- Maximum throughput is 1 flit/cycle while crd_cnt>=1 and the receiver returns 1 credit/cycle.
- link_en dropping mid-burst: the flit already registered still presents its txflitv; there are no further pops.
- link_en reasserting in DEACT is ignored until STOP is reached.
- Reset mid-operation: all state is cleared immediately (async). Held credits are lost; the receiver is reset with the link.

Optional Feature:
SNF_FLIT_TX_PEND_EN
- Defined: txflitpend = (state==RUN & ~fifo_empty & crd_cnt!=0) | (state==DEACT & crd_cnt!=0). This is combinational and asserted exactly one cycle before the corresponding txflitv.
- Undefined: txflitpend is tied to 1'b1 (always-pending, protocol-legal, higher receiver power).

Test Plan:
- Reset, link_en=1, no credits, FIFO holding 3 flits -> STOP->ACT->RUN, fifo_rd_en stays 0, txflitv=0, crd_cnt=0.
- In RUN, pulse txlcrdv 2 cycles with FIFO holding A,B,C -> A and B sent on consecutive txflitv, 1 cycle after each pop; C held; crd_cnt returns to 0.
- Steady txlcrdv=1 every cycle after crd_cnt=1, FIFO holding 8 flits -> 8 back-to-back txflitv cycles; crd_cnt stays 1 throughout.
- crd_cnt=4 (MAX_CRD), txlcrdv=1, FIFO empty -> crd_cnt stays 4, crd_err=1 and remains 1 until rst.
- RUN with crd_cnt=3, drop link_en -> DEACT; 3 consecutive txflitv with txlcrdrtn=1 and txflit=0; then STOP, link_active=0.
- With SNF_FLIT_TX_PEND_EN: txflitpend rises exactly one cycle before each txflitv. Without it: txflitpend=1 constantly.
